mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Initiator side of the data-memory port: accepts one load/store request from the core via a valid/ready handshake and drives the mem port.
- Mem port: synchronous write, combinational read, BYTE/HALFWORD/WORD widths, native sign extension, naturally-aligned accesses only.
- Issues aligned requests as one access. Splits misaligned requests into byte beats, then assembles and sign-extends load data.
- Sits between the core's execute/writeback stage and the data memory.

Parameters:
- SplitEnable, 1, when 1 misaligned requests are split into byte beats; when 0 they complete with rsp_error and no memory access.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_write  in  1  1=store, 0=load.
- req_width  in  mem_width_t  BYTE/HALFWORD/WORD.
- req_sign_extend  in  1  loads only: sign-extend result.
- req_address  in  DMemAddrWidth  byte address.
- req_wdata  in  32  store data, least-significant bytes used for narrow widths.
- rsp_valid  out  1  one-cycle completion pulse for loads and stores.
- rsp_rdata  out  32  load result, valid with rsp_valid; 0 for stores/errors.
- rsp_error  out  1  valid with rsp_valid; request not performed.
- mem_write_enable  out  1  to mem write_enable.
- mem_width  out  mem_width_t  to mem width.
- mem_sign_extend  out  1  to mem sign_extend.
- mem_address  out  DMemAddrWidth  to mem address.
- mem_data_in  out  32  to mem data_in.
- mem_data_out  in  32  from mem data_out (combinational, same cycle).
- mem_alignment_error  in  1  from mem; must never be 1 during ACCESS (assertion only).

Behaviour:
- Reset (reset_n=0, immediate)
  - State IDLE, beat counter 0, latched request cleared.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0, req_ready=1.
  - mem_write_enable=0, mem_address=0, mem_data_in=0, mem_width=WORD, mem_sign_extend=0.
- State IDLE
  - req_ready=1.
  - On posedge with req_valid=1, latch the request.
  - Invalid width, or misaligned with SplitEnable=0 → RESP with error.
  - Otherwise → ACCESS, beat=0.
- Misaligned definition
  - HALFWORD with address[0]=1.
  - WORD with address[1:0]!=0.
  - BYTE is never misaligned.
- Beat count N
  - Aligned: N=1, native width; mem_sign_extend=req_sign_extend.
  - Misaligned HALFWORD: N=2. Misaligned WORD: N=4.
  - Misaligned beats use width BYTE, mem_sign_extend=0.
- State ACCESS, beat k
  - mem_address = latched address + k, modulo 2^DMemAddrWidth (wraps to 0).
  - mem_write_enable = req_write.
  - Aligned store: mem_data_in = req_wdata.
  - Split store: mem_data_in[7:0] = req_wdata[8k+7:8k].
  - Loads:
    - Aligned: capture mem_data_out at the posedge.
    - Split: capture mem_data_out[7:0] into assembly byte k.
  - k==N-1 → RESP; else k+1.
- State RESP (exactly one cycle, then IDLE)
  - rsp_valid=1; req_ready=0; mem_write_enable=0.
  - Split load with sign extend: bits above the top assembled byte replicate its bit 7. Otherwise zero-filled.
- Outside ACCESS
  - mem_write_enable=0.
  - Other mem_* hold last driven values.
- Latency (accept edge = edge 0)
  - N access cycles, rsp_valid during cycle N+1, next accept possible at edge N+2.
  - Error path: rsp_valid in cycle 1, no access cycles.
- Reset mid-operation
  - Abort immediately, no response.
  - Bytes already written stay written; no rollback.
- req_* changes while not in IDLE are ignored.

Decomposition:
- Shared packages:
  - mem_width_t and its BYTE/HALFWORD/WORD encodings stay in mem_pkg.
  - DMemAddrWidth and DMemSize stay in config_pkg.
- New typedef in mem_pkg: seq_state_t {IDLE, ACCESS, RESP}.
- One natural sub-module: mem_load_align, a combinational assembler/sign-extender of up to 4 bytes given width and sign_extend.

Test Plan:
- Aligned store WORD 0xDEADBEEF @0x10, then load WORD @0x10 → one ACCESS cycle each; rsp_rdata=0xDEADBEEF in cycle 2 after accept; rsp_error=0.
- Misaligned store WORD 0x11223344 @0x13 → 4 byte writes at 0x13..0x16 with 0x44,0x33,0x22,0x11; aligned load WORD @0x10 → byte3=0x44; load WORD @0x13 → 0x11223344, rsp in cycle 5.
- Bytes 0x01@0x13, 0x80@0x14; load HALFWORD @0x13 signed → 0xFFFF8001; unsigned → 0x00008001.
- SplitEnable=0, store HALFWORD @0x21 → rsp_error=1, rsp_rdata=0 in cycle 1; mem_write_enable never asserted; memory unchanged.
- Misaligned WORD load @(2^DMemAddrWidth-2) → beat addresses 2^W-2, 2^W-1, 0, 1; mem_alignment_error=0 throughout.
- reset_n low during beat 2 of misaligned WORD store @0x31 → all outputs reset immediately; 0x31,0x32 written, 0x33,0x34 unchanged; next request accepted normally.

Source files
------------

// File: rtl/config_pkg.sv
// Data-memory geometry shared by the core and its memory port.
// Address width sets the byte address space; size follows from it.
package config_pkg;
  localparam int DMemAddrWidth = 12;
  localparam int DMemSize = 1 << DMemAddrWidth;
endpackage

// File: rtl/mem_pkg.sv
// Memory-port width encodings and sequencer state type.
// Encoding 2'b11 is not a legal width and is rejected by the sequencer.
package mem_pkg;
  typedef enum logic [1:0] {
    BYTE     = 2'b00,
    HALFWORD = 2'b01,
    WORD     = 2'b10
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } seq_state_t;
endpackage

// File: rtl/mem_load_align.sv
// Packs up to four little-endian bytes into a load result,
// sign- or zero-extending above the top byte of the given width.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] bytes_i,
  input  mem_width_t  width_i,
  input  logic        sext_i,
  output logic [31:0] data_o
);
  logic fill_b;
  logic fill_h;

  assign fill_b = sext_i & bytes_i[7];
  assign fill_h = sext_i & bytes_i[15];

  // Width-dependent extension of the assembled bytes.
  always_comb begin
    data_o = bytes_i;
    unique case (1'b1)
      width_i == BYTE:
        data_o = {{24{fill_b}}, bytes_i[7:0]};
      width_i == HALFWORD:
        data_o = {{16{fill_h}}, bytes_i[15:0]};
      default:
        data_o = bytes_i;
    endcase
  end
endmodule

// File: rtl/mem_access_sequencer.sv
// Load/store initiator for the data-memory port. Aligned requests
// take one access; misaligned ones are split into byte beats.
module mem_access_sequencer
  import mem_pkg::*;
  import config_pkg::*;
#(
  parameter bit SplitEnable = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  mem_width_t               req_width,
  input  logic                     req_sign_extend,
  input  logic [DMemAddrWidth-1:0] req_address,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_error,
  output logic                     mem_write_enable,
  output mem_width_t               mem_width,
  output logic                     mem_sign_extend,
  output logic [DMemAddrWidth-1:0] mem_address,
  output logic [31:0]              mem_data_in,
  input  logic [31:0]              mem_data_out,
  input  logic                     mem_alignment_error
);
  localparam int AW = DMemAddrWidth;

  seq_state_t        state_q;
  logic [1:0]        beat_q;
  logic [1:0]        last_q;
  logic              split_q;
  logic              write_q;
  mem_width_t        width_q;
  logic              sext_q;
  logic [AW-1:0]     addr_q;
  logic [3:0][7:0]   wdata_q;
  logic [3:0][7:0]   bytes_q;

  logic              misal;
  logic              width_ok;
  logic [1:0]        last_d;
  logic [1:0]        beat_d;
  logic [AW-1:0]     addr_d;
  logic [3:0][7:0]   bytes_d;
  logic [31:0]       split_rdata;

  assign req_ready = (state_q == IDLE);

  assign width_ok = (req_width == BYTE)
                  | (req_width == HALFWORD)
                  | (req_width == WORD);

  assign misal = ((req_width == HALFWORD) & req_address[0])
               | ((req_width == WORD) & (|req_address[1:0]));

  assign last_d = !misal ? 2'd0
                : (req_width == WORD) ? 2'd3 : 2'd1;

  assign beat_d = beat_q + 2'd1;
  assign addr_d = addr_q + AW'(beat_d);

  // Assembly buffer with the current beat's byte dropped in.
  always_comb begin
    bytes_d = bytes_q;
    bytes_d[beat_q] = mem_data_out[7:0];
  end

  mem_load_align u_align (
    .bytes_i (bytes_d),
    .width_i (width_q),
    .sext_i  (sext_q),
    .data_o  (split_rdata)
  );

  // Sequencer FSM with registered response and mem-port outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      beat_q           <= 2'd0;
      last_q           <= 2'd0;
      split_q          <= 1'b0;
      write_q          <= 1'b0;
      width_q          <= WORD;
      sext_q           <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      bytes_q          <= '0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      rsp_error        <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_width        <= WORD;
      mem_sign_extend  <= 1'b0;
      mem_address      <= '0;
      mem_data_in      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            width_q <= req_width;
            sext_q  <= req_sign_extend;
            addr_q  <= req_address;
            wdata_q <= req_wdata;
            split_q <= misal;
            last_q  <= last_d;
            beat_q  <= 2'd0;
            bytes_q <= '0;
            if (!width_ok || (misal && !SplitEnable)) begin
              state_q   <= RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
            end else begin
              state_q          <= ACCESS;
              mem_write_enable <= req_write;
              mem_address      <= req_address;
              mem_width        <= misal ? BYTE : req_width;
              mem_sign_extend  <= misal ? 1'b0
                                        : req_sign_extend;
              mem_data_in      <= misal
                                ? {24'd0, req_wdata[7:0]}
                                : req_wdata;
            end
          end
        end
        ACCESS: begin
          bytes_q <= bytes_d;
          if (beat_q == last_q) begin
            state_q          <= RESP;
            mem_write_enable <= 1'b0;
            rsp_valid        <= 1'b1;
            if (!write_q)
              rsp_rdata <= split_q ? split_rdata
                                   : mem_data_out;
          end else begin
            beat_q      <= beat_d;
            mem_address <= addr_d;
            mem_data_in <= {24'd0, wdata_q[beat_d]};
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sequencer only ever presents naturally aligned beats.
  a_aligned: assert property (
    @(posedge clk) disable iff (!reset_n)
    (state_q == ACCESS) |-> !mem_alignment_error
  );
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a byte-array memory.
// Second instance runs with splitting disabled.
module tb_mem_access_sequencer;
  import mem_pkg::*;
  import config_pkg::*;

  localparam int AW = DMemAddrWidth;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic wipe = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  mem_width_t    req_width = WORD;
  logic          req_sext = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic          m_we;
  mem_width_t    m_width;
  logic          m_sext;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_din;
  logic [31:0]   m_rd;
  logic          m_aerr;

  logic          req_valid0 = 1'b0;
  logic          req_ready0;
  logic          rsp_valid0;
  logic [31:0]   rsp_rdata0;
  logic          rsp_error0;
  logic          m_we0;
  mem_width_t    m_width0;
  logic          m_sext0;
  logic [AW-1:0] m_addr0;
  logic [31:0]   m_din0;

  logic [7:0]    mem [0:DMemSize-1];
  logic [AW-1:0] a1, a2, a3;
  bit            aerr_seen = 1'b0;
  bit            we0_seen = 1'b0;
  int            total = 0;
  int            bad = 0;

  mem_access_sequencer #(.SplitEnable(1'b1)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_width           (req_width),
    .req_sign_extend     (req_sext),
    .req_address         (req_addr),
    .req_wdata           (req_wdata),
    .rsp_valid           (rsp_valid),
    .rsp_rdata           (rsp_rdata),
    .rsp_error           (rsp_error),
    .mem_write_enable    (m_we),
    .mem_width           (m_width),
    .mem_sign_extend     (m_sext),
    .mem_address         (m_addr),
    .mem_data_in         (m_din),
    .mem_data_out        (m_rd),
    .mem_alignment_error (m_aerr)
  );

  mem_access_sequencer #(.SplitEnable(1'b0)) dut0 (
    .clk                 (clk),
    .reset_n             (reset_n),
    .req_valid           (req_valid0),
    .req_ready           (req_ready0),
    .req_write           (req_write),
    .req_width           (req_width),
    .req_sign_extend     (req_sext),
    .req_address         (req_addr),
    .req_wdata           (req_wdata),
    .rsp_valid           (rsp_valid0),
    .rsp_rdata           (rsp_rdata0),
    .rsp_error           (rsp_error0),
    .mem_write_enable    (m_we0),
    .mem_width           (m_width0),
    .mem_sign_extend     (m_sext0),
    .mem_address         (m_addr0),
    .mem_data_in         (m_din0),
    .mem_data_out        (32'd0),
    .mem_alignment_error (1'b0)
  );

  assign a1 = m_addr + AW'(1);
  assign a2 = m_addr + AW'(2);
  assign a3 = m_addr + AW'(3);

  always_comb begin
    m_rd = {mem[a3], mem[a2], mem[a1], mem[m_addr]};
    if (m_width == BYTE)
      m_rd = {{24{m_sext & mem[m_addr][7]}}, mem[m_addr]};
    else if (m_width == HALFWORD)
      m_rd = {{16{m_sext & mem[a1][7]}}, mem[a1], mem[m_addr]};
  end

  assign m_aerr = ((m_width == HALFWORD) & m_addr[0])
                | ((m_width == WORD) & (|m_addr[1:0]));

  always @(posedge clk) begin
    if (wipe) begin
      for (int i = 0; i < DMemSize; i++) mem[i] <= 8'h00;
    end else if (m_we) begin
      mem[m_addr] <= m_din[7:0];
      if (m_width != BYTE) mem[a1] <= m_din[15:8];
      if (m_width == WORD) begin
        mem[a2] <= m_din[23:16];
        mem[a3] <= m_din[31:24];
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n && m_aerr) aerr_seen = 1'b1;
    if (m_we0) we0_seen = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag,
                        input logic wr,
                        input mem_width_t w,
                        input logic sx,
                        input logic [AW-1:0] ad,
                        input logic [31:0] wd,
                        input int n,
                        input logic [31:0] exp_rd,
                        input logic exp_err);
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    int            wait_c;
    wait_c = 0;
    while (!req_ready && wait_c < 8) begin
      step();
      wait_c++;
    end
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_write = wr;
    req_width = w;
    req_sext  = sx;
    req_addr  = ad;
    req_wdata = wd;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      ea = ad + AW'(k);
      chk({tag, " addr"}, 32'(m_addr), 32'(ea));
      chk({tag, " we"}, 32'(m_we), 32'(wr));
      chk({tag, " width"}, 32'(m_width),
          32'((n > 1) ? BYTE : w));
      chk({tag, " msext"}, 32'(m_sext),
          32'((n > 1) ? 1'b0 : sx));
      chk({tag, " busy"}, {31'd0, req_ready | rsp_valid},
          32'd0);
      if (wr) begin
        ed = (n > 1) ? {24'd0, wd[8*k +: 8]} : wd;
        chk({tag, " din"}, m_din, ed);
      end
      step();
    end
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " rsp_rdata"}, rsp_rdata, exp_rd);
    chk({tag, " rsp_error"}, 32'(rsp_error), 32'(exp_err));
    chk({tag, " resp_we"}, 32'(m_we), 32'd0);
    step();
    chk({tag, " idle"}, {30'd0, rsp_valid, req_ready},
        32'd1);
  endtask

  initial begin
    step();
    step();
    wipe = 1'b0;
    step();
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst rsp_error", 32'(rsp_error), 32'd0);
    chk("rst we", 32'(m_we), 32'd0);
    chk("rst addr", 32'(m_addr), 32'd0);
    chk("rst din", m_din, 32'd0);
    chk("rst width", 32'(m_width), 32'(WORD));
    chk("rst msext", 32'(m_sext), 32'd0);
    reset_n = 1'b1;
    step();

    do_req("st_w", 1'b1, WORD, 1'b0, 12'h010,
           32'hDEADBEEF, 1, 32'h0, 1'b0);
    do_req("ld_w", 1'b0, WORD, 1'b0, 12'h010,
           32'h0, 1, 32'hDEADBEEF, 1'b0);

    do_req("st_mis", 1'b1, WORD, 1'b0, 12'h013,
           32'h11223344, 4, 32'h0, 1'b0);
    chk("m13", 32'(mem[12'h013]), 32'h44);
    chk("m14", 32'(mem[12'h014]), 32'h33);
    chk("m15", 32'(mem[12'h015]), 32'h22);
    chk("m16", 32'(mem[12'h016]), 32'h11);
    do_req("ld_w10", 1'b0, WORD, 1'b0, 12'h010,
           32'h0, 1, 32'h44ADBEEF, 1'b0);
    do_req("ld_mis", 1'b0, WORD, 1'b0, 12'h013,
           32'h0, 4, 32'h11223344, 1'b0);

    do_req("st_b13", 1'b1, BYTE, 1'b0, 12'h013,
           32'hAAAAAA01, 1, 32'h0, 1'b0);
    do_req("st_b14", 1'b1, BYTE, 1'b0, 12'h014,
           32'h55555580, 1, 32'h0, 1'b0);
    do_req("ld_hs", 1'b0, HALFWORD, 1'b1, 12'h013,
           32'h0, 2, 32'hFFFF8001, 1'b0);
    do_req("ld_hu", 1'b0, HALFWORD, 1'b0, 12'h013,
           32'h0, 2, 32'h00008001, 1'b0);
    do_req("ld_bs", 1'b0, BYTE, 1'b1, 12'h014,
           32'h0, 1, 32'hFFFFFF80, 1'b0);
    do_req("ld_ha", 1'b0, HALFWORD, 1'b1, 12'h014,
           32'h0, 1, 32'h00002280, 1'b0);

    do_req("st_wrap", 1'b1, WORD, 1'b0, 12'hFFE,
           32'hA1B2C3D4, 4, 32'h0, 1'b0);
    chk("m000", 32'(mem[12'h000]), 32'hB2);
    do_req("ld_wrap", 1'b0, WORD, 1'b0, 12'hFFE,
           32'h0, 4, 32'hA1B2C3D4, 1'b0);

    do_req("bad_w", 1'b1, mem_width_t'(2'b11), 1'b0,
           12'h040, 32'h12345678, 0, 32'h0, 1'b1);
    chk("m040", 32'(mem[12'h040]), 32'h00);

    req_write = 1'b1;
    req_width = HALFWORD;
    req_sext  = 1'b0;
    req_addr  = 12'h021;
    req_wdata = 32'h0000BEEF;
    req_valid0 = 1'b1;
    step();
    req_valid0 = 1'b0;
    chk("ns rsp_valid", 32'(rsp_valid0), 32'd1);
    chk("ns rsp_error", 32'(rsp_error0), 32'd1);
    chk("ns rsp_rdata", rsp_rdata0, 32'd0);
    chk("ns ready", 32'(req_ready0), 32'd0);
    step();
    chk("ns idle", 32'(req_ready0), 32'd1);
    chk("ns rsp_done", 32'(rsp_valid0), 32'd0);
    chk("ns no_we", 32'(we0_seen), 32'd0);

    req_write = 1'b1;
    req_width = WORD;
    req_addr  = 12'h031;
    req_wdata = 32'h55667788;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("mid beat2", 32'(m_addr), 32'h033);
    reset_n = 1'b0;
    #1;
    chk("mid rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid we", 32'(m_we), 32'd0);
    chk("mid ready", 32'(req_ready), 32'd1);
    chk("mid addr", 32'(m_addr), 32'd0);
    chk("mid din", m_din, 32'd0);
    step();
    chk("m31", 32'(mem[12'h031]), 32'h88);
    chk("m32", 32'(mem[12'h032]), 32'h77);
    chk("m33", 32'(mem[12'h033]), 32'h00);
    chk("m34", 32'(mem[12'h034]), 32'h00);
    reset_n = 1'b1;
    step();
    do_req("ld_post", 1'b0, WORD, 1'b0, 12'h030,
           32'h0, 1, 32'h00778800, 1'b0);

    chk("align_err", 32'(aerr_seen), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
